// File: rtl/instruction_register_pkg.sv
// Shared instruction-word constants and field layout for the matrix-multiply core.
package instruction_register_pkg;

    localparam int INSTR_W         = 17;
    localparam int INSTR_OPCODE_W  = 5;
    localparam int INSTR_OPERAND_W = INSTR_W - INSTR_OPCODE_W;

    // Opcode occupies the MSBs, so field order matches the packed bit order.
    typedef struct packed {
        logic [INSTR_OPCODE_W-1:0]  opcode;
        logic [INSTR_OPERAND_W-1:0] operand;
    } instr_t;

    function automatic instr_t split_instr(input logic [INSTR_W-1:0] word);
        instr_t f;
        f = instr_t'(word);
        return f;
    endfunction

endpackage

// File: rtl/instruction_register.sv
// Current-instruction holding register with pre-split opcode/operand fields.
module instruction_register
    import instruction_register_pkg::*;
#(
    parameter int               WIDTH    = INSTR_W,
    parameter int               OPCODE_W = INSTR_OPCODE_W,
    parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write,
    input  logic [WIDTH-1:0]      data_in,
    output logic [WIDTH-1:0]      data_out,
    output logic [OPCODE_W-1:0]   opcode,
    output logic [WIDTH-OPCODE_W-1:0] operand,
    output logic                  ir_valid
);

    generate
        if (OPCODE_W >= WIDTH) begin : g_bad_opcode_w
            $error("instruction_register: OPCODE_W must be smaller than WIDTH");
        end
    endgenerate

    logic [WIDTH-1:0] data_p0;
    logic             vld_p0;

    // Stage p0: the only register; reset outranks a same-cycle load.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_p0 <= RST_VAL;
            vld_p0  <= 1'b0;
        end else if (write) begin
            data_p0 <= data_in;
            vld_p0  <= 1'b1;
        end
    end

    assign data_out = data_p0;
    assign ir_valid = vld_p0;
    assign opcode   = data_p0[WIDTH-1 -: OPCODE_W];
    assign operand  = data_p0[WIDTH-OPCODE_W-1:0];

endmodule

// File: tb/tb_instruction_register.sv
// Scoreboard bench for instruction_register: stimulus queues expectations, monitor checks after each edge.
module tb_instruction_register;

    localparam int W  = 17;
    localparam int OW = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            write;
    logic [W-1:0]    data_in;
    logic [W-1:0]    data_out;
    logic [OW-1:0]   opcode;
    logic [W-OW-1:0] operand;
    logic            ir_valid;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [W-1:0]    d;
        logic [OW-1:0]   op;
        logic [W-OW-1:0] opd;
        logic            v;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];

    instruction_register #(
        .WIDTH   (W),
        .OPCODE_W(OW),
        .RST_VAL ('0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .write   (write),
        .data_in (data_in),
        .data_out(data_out),
        .opcode  (opcode),
        .operand (operand),
        .ir_valid(ir_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and queue what must appear after the next rising edge.
    task automatic step(input string nm, input logic r, input logic w, input logic [W-1:0] din,
                        input logic [W-1:0] ed, input logic [OW-1:0] eop,
                        input logic [W-OW-1:0] eopd, input logic ev);
        exp_t e;
        @(negedge clk);
        rst     = r;
        write   = w;
        data_in = din;
        e.d   = ed;
        e.op  = eop;
        e.opd = eopd;
        e.v   = ev;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: every rising edge with an outstanding expectation is checked 1 time unit later.
    always begin
        exp_t  e;
        string nm;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            check({nm, ".data_out"}, 32'(data_out), 32'(e.d));
            check({nm, ".opcode"},   32'(opcode),   32'(e.op));
            check({nm, ".operand"},  32'(operand),  32'(e.opd));
            check({nm, ".ir_valid"}, 32'(ir_valid), 32'(e.v));
        end
    end

    initial begin
        logic [W-1:0] pat;
        int           waited;
        rst     = 1'b1;
        write   = 1'b0;
        data_in = '0;

        step("reset",      1'b1, 1'b0, 17'h00000, 17'h00000, 5'h00, 12'h000, 1'b0);
        step("init_load",  1'b0, 1'b1, 17'h00024, 17'h00024, 5'h00, 12'h024, 1'b1);
        step("hold1",      1'b0, 1'b0, 17'h000E5, 17'h00024, 5'h00, 12'h024, 1'b1);
        step("hold2",      1'b0, 1'b0, 17'h000E5, 17'h00024, 5'h00, 12'h024, 1'b1);
        step("hold3",      1'b0, 1'b0, 17'h000E5, 17'h00024, 5'h00, 12'h024, 1'b1);
        step("hold_x",     1'b0, 1'b0, 'x,        17'h00024, 5'h00, 12'h024, 1'b1);
        step("sync_reset", 1'b1, 1'b0, 17'h000E5, 17'h00000, 5'h00, 12'h000, 1'b0);
        #1;
        check("pre_reset_edge.data_out", 32'(data_out), 32'h00024);
        check("pre_reset_edge.ir_valid", 32'(ir_valid), 32'h1);

        step("load_abcd",  1'b0, 1'b1, 17'h0ABCD, 17'h0ABCD, 5'h0A, 12'hBCD, 1'b1);
        step("rst_prio",   1'b1, 1'b1, 17'h1FFFF, 17'h00000, 5'h00, 12'h000, 1'b0);
        step("split_hi",   1'b0, 1'b1, 17'h1F000, 17'h1F000, 5'h1F, 12'h000, 1'b1);
        step("split_lo",   1'b0, 1'b1, 17'h00FFF, 17'h00FFF, 5'h00, 12'hFFF, 1'b1);

        for (int i = 0; i < W; i++) begin
            pat = '0;
            pat[i] = 1'b1;
            step($sformatf("walk%0d", i), 1'b0, 1'b1, pat, pat,
                 pat[W-1 -: OW], pat[W-OW-1:0], 1'b1);
        end
        step("final_hold", 1'b0, 1'b0, 17'h15555, 17'h10000, 5'h10, 12'h000, 1'b1);

        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: bench exceeded time limit, required completion");
        $fatal(1, "timeout");
    end

endmodule
